// File: rtl/aline_fire_sequencer_if.sv
// Delay-store handshake between the A-line fire sequencer (master) and the
// per-channel delay store of the image config block (slave).
interface aline_fire_sequencer_if;
  logic         rd_en;
  logic [3:0]   which_aline;
  logic         updating_delays;
  logic [127:0] ch_delay;

  modport master (
    output rd_en,
    output which_aline,
    input  updating_delays,
    input  ch_delay
  );

  modport slave (
    input  rd_en,
    input  which_aline,
    output updating_delays,
    output ch_delay
  );
endinterface

// File: rtl/aline_fire_sequencer.sv
// Per-A-line delay fetch, snapshot and per-channel trigger strobe sequencer
// sitting between the config delay store and the transmit pulsers.
module aline_fire_sequencer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = 1000,
  parameter int GAP_W       = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop_en,
  input  logic                          intaking_configs,
  input  logic [7:0]                    channel_select,
  input  logic [4:0]                    aline_select,
  aline_fire_sequencer_if.master        cfg,
  output logic [7:0]                    fire,
  output logic                          busy,
  output logic                          aline_done,
  output logic                          frame_done,
  output logic                          timeout_err
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REQ       = 3'd1;
  localparam logic [2:0] WAIT_ACK  = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] FIRE      = 3'd4;
  localparam logic [2:0] GAP       = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [3:0]       which_aline_q, which_aline_d;
  logic [4:0]       nlines_q, nlines_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]      fire_cnt_q, fire_cnt_d;
  logic [127:0]     delay_q, delay_d;
  logic [7:0]       en_q, en_d;
  logic [15:0]      max_q, max_d;
  logic             stop_seen_q, stop_seen_d;
  logic             timeout_err_q, timeout_err_d;
  logic             rd_en_q, rd_en_d;
  logic [7:0]       fire_q, fire_d;
  logic             aline_done_q, aline_done_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      max_in;
  logic [15:0]      fire_cnt_inc;

  function automatic logic [15:0] max_enabled(input logic [127:0] dly, input logic [7:0] en);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (en[i] && (dly[16*i +: 16] > m)) m = dly[16*i +: 16];
    end
    return m;
  endfunction

  assign max_in       = max_enabled(cfg.ch_delay, channel_select);
  assign fire_cnt_inc = fire_cnt_q + 16'd1;

  // Strobes are computed one cycle early so the registered fire bit lines up
  // with the cycle in which the fire counter equals that channel's delay.
  always_comb begin
    state_d       = state_q;
    which_aline_d = which_aline_q;
    nlines_d      = nlines_q;
    ack_cnt_d     = ack_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    fire_cnt_d    = fire_cnt_q;
    delay_d       = delay_q;
    en_d          = en_q;
    max_d         = max_q;
    stop_seen_d   = stop_seen_q;
    timeout_err_d = timeout_err_q;
    fire_d        = '0;
    aline_done_d  = 1'b0;
    frame_done_d  = 1'b0;

    if ((state_q != IDLE) && (stop || intaking_configs)) stop_seen_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start && !intaking_configs && (aline_select != 5'd0)) begin
          state_d       = REQ;
          which_aline_d = 4'd0;
          timeout_err_d = 1'b0;
          stop_seen_d   = 1'b0;
          nlines_d      = (aline_select > 5'd16) ? 5'd16 : aline_select;
        end
      end
      REQ: begin
        state_d   = WAIT_ACK;
        ack_cnt_d = '0;
      end
      WAIT_ACK: begin
        if (cfg.updating_delays) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!cfg.updating_delays) begin
          state_d      = FIRE;
          delay_d      = cfg.ch_delay;
          en_d         = channel_select;
          max_d        = max_in;
          fire_cnt_d   = '0;
          aline_done_d = (max_in == 16'd0);
          for (int i = 0; i < 8; i++) begin
            fire_d[i] = channel_select[i] && (cfg.ch_delay[16*i +: 16] == 16'd0);
          end
        end
      end
      FIRE: begin
        if (fire_cnt_q == max_q) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          fire_cnt_d   = fire_cnt_inc;
          aline_done_d = (fire_cnt_inc == max_q);
          for (int i = 0; i < 8; i++) begin
            fire_d[i] = en_q[i] && (delay_q[16*i +: 16] == fire_cnt_inc);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (stop_seen_q || stop || intaking_configs) begin
            state_d = IDLE;
          end else if ({1'b0, which_aline_q} < (nlines_q - 5'd1)) begin
            which_aline_d = which_aline_q + 4'd1;
            state_d       = REQ;
          end else begin
            frame_done_d = 1'b1;
            if (loop_en) begin
              which_aline_d = 4'd0;
              state_d       = REQ;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_en_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      which_aline_q <= '0;
      nlines_q      <= '0;
      ack_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      fire_cnt_q    <= '0;
      delay_q       <= '0;
      en_q          <= '0;
      max_q         <= '0;
      stop_seen_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      rd_en_q       <= 1'b0;
      fire_q        <= '0;
      aline_done_q  <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      which_aline_q <= which_aline_d;
      nlines_q      <= nlines_d;
      ack_cnt_q     <= ack_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      fire_cnt_q    <= fire_cnt_d;
      delay_q       <= delay_d;
      en_q          <= en_d;
      max_q         <= max_d;
      stop_seen_q   <= stop_seen_d;
      timeout_err_q <= timeout_err_d;
      rd_en_q       <= rd_en_d;
      fire_q        <= fire_d;
      aline_done_q  <= aline_done_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign cfg.rd_en       = rd_en_q;
  assign cfg.which_aline = which_aline_q;
  assign fire            = fire_q;
  assign busy            = (state_q != IDLE);
  assign aline_done      = aline_done_q;
  assign frame_done      = frame_done_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_aline_fire_sequencer.sv
// Directed bench for aline_fire_sequencer: the bench plays the delay store and
// scoreboards every fire/aline_done/frame_done cycle against its own timing model.
module tb_aline_fire_sequencer;
  localparam int ACK_TIMEOUT = 16;
  localparam int GAP_CYCLES  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic       intaking_configs;
  logic [7:0] channel_select;
  logic [4:0] aline_select;
  logic [7:0] fire;
  logic       busy;
  logic       aline_done;
  logic       frame_done;
  logic       timeout_err;

  aline_fire_sequencer_if cfg_if();

  aline_fire_sequencer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .GAP_CYCLES (GAP_CYCLES),
    .GAP_W      (20)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stop            (stop),
    .loop_en         (loop_en),
    .intaking_configs(intaking_configs),
    .channel_select  (channel_select),
    .aline_select    (aline_select),
    .cfg             (cfg_if),
    .fire            (fire),
    .busy            (busy),
    .aline_done      (aline_done),
    .frame_done      (frame_done),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] fire;
    logic       aline_done;
    logic       frame_done;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  checks   = 0;
  int  errors   = 0;
  int  rd_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Any strobe or done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cfg_if.rd_en) rd_count++;
    if ((fire != 8'h00) || aline_done || frame_done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", {22'd0, fire, aline_done, frame_done}, 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        checkOutput("event_cycle", cyc, mon_ev.cyc);
        checkOutput("event_fire", {24'd0, fire}, {24'd0, mon_ev.fire});
        checkOutput("event_aline_done", {31'd0, aline_done}, {31'd0, mon_ev.aline_done});
        checkOutput("event_frame_done", {31'd0, frame_done}, {31'd0, mon_ev.frame_done});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] lines, input logic loop);
    aline_select = lines;
    loop_en      = loop;
    start        = 1'b1;
    tick(1);
    start        = 1'b0;
  endtask

  task automatic wait_rd_en(input string tag, input int bound);
    int n;
    n = 0;
    while (!cfg_if.rd_en && (n < bound)) begin
      tick(1);
      n++;
    end
    checkOutput(tag, {31'd0, cfg_if.rd_en}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy && (n < bound)) begin
      tick(1);
      n++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [127:0] pack8(input int d0, input int d1, input int d2, input int d3,
                                         input int d4, input int d5, input int d6, input int d7);
    return {16'(d7), 16'(d6), 16'(d5), 16'(d4), 16'(d3), 16'(d2), 16'(d1), 16'(d0)};
  endfunction

  // Called in the rd_en cycle: ack one cycle later, stay busy two cycles, then
  // present the delays; predicted events are queued, then the inputs are scrambled.
  task automatic serve_line(input logic [127:0] dly, input logic [7:0] sel, input bit last,
                            output int drop_cyc, output int mx);
    logic [7:0] m;
    tick(1);
    cfg_if.updating_delays = 1'b1;
    cfg_if.ch_delay        = ~dly;
    tick(2);
    cfg_if.ch_delay        = dly;
    channel_select         = sel;
    cfg_if.updating_delays = 1'b0;
    drop_cyc = cyc;
    mx = 0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i] && (int'(dly[16*i +: 16]) > mx)) mx = int'(dly[16*i +: 16]);
    end
    for (int t = 0; t <= mx; t++) begin
      m = '0;
      for (int i = 0; i < 8; i++) begin
        if (sel[i] && (int'(dly[16*i +: 16]) == t)) m[i] = 1'b1;
      end
      if ((m != 8'h00) || (t == mx)) exp_q.push_back('{drop_cyc + 1 + t, m, (t == mx), 1'b0});
    end
    if (last) exp_q.push_back('{drop_cyc + 2 + mx + GAP_CYCLES, 8'h00, 1'b0, 1'b1});
    tick(1);
    cfg_if.ch_delay = {$urandom, $urandom, $urandom, $urandom};
    channel_select  = 8'($urandom);
  endtask

  initial begin
    int rd_base;
    int drop_cyc;
    int mx;
    int exp_cyc;

    rst                    = 1'b1;
    start                  = 1'b0;
    stop                   = 1'b0;
    loop_en                = 1'b0;
    intaking_configs       = 1'b0;
    channel_select         = 8'h00;
    aline_select           = 5'd0;
    cfg_if.updating_delays = 1'b0;
    cfg_if.ch_delay        = '0;
    #2 rst = 1'b0;
    tick(3);

    $display("[TB] reset values");
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_fire", {24'd0, fire}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, cfg_if.rd_en}, 32'd0);
    checkOutput("rst_which", {28'd0, cfg_if.which_aline}, 32'd0);
    checkOutput("rst_done", {30'd0, aline_done, frame_done}, 32'd0);
    checkOutput("rst_timeout", {31'd0, timeout_err}, 32'd0);
    rst = 1'b1;
    tick(2);

    $display("[TB] single A-line, ch0=3 ch2=7");
    rd_base = rd_count;
    applyStimulus(5'd1, 1'b0);
    wait_rd_en("t1_rd_en", 4);
    checkOutput("t1_which", {28'd0, cfg_if.which_aline}, 32'd0);
    serve_line(pack8(3, 1, 7, 0, 2, 50, 0, 9), 8'h05, 1'b1, drop_cyc, mx);
    wait_idle("t1_idle", mx + GAP_CYCLES + 10);
    tick(2);
    checkOutput("t1_queue", exp_q.size(), 32'd0);
    checkOutput("t1_rd_pulses", rd_count - rd_base, 32'd1);

    $display("[TB] three A-line frame");
    rd_base = rd_count;
    exp_cyc = 0;
    applyStimulus(5'd3, 1'b0);
    for (int l = 0; l < 3; l++) begin
      wait_rd_en("t2_rd_en", GAP_CYCLES + 20);
      if (l > 0) checkOutput("t2_rd_spacing", cyc, exp_cyc);
      checkOutput("t2_which", {28'd0, cfg_if.which_aline}, 32'(l));
      serve_line(pack8(l, l + 2, 4, 1, 0, 6, 3, 5), 8'h13 << l, (l == 2), drop_cyc, mx);
      exp_cyc = drop_cyc + 2 + mx + GAP_CYCLES;
    end
    wait_idle("t2_idle", GAP_CYCLES + 20);
    checkOutput("t2_idle_cycle", cyc, exp_cyc);
    tick(5);
    checkOutput("t2_queue", exp_q.size(), 32'd0);
    checkOutput("t2_rd_pulses", rd_count - rd_base, 32'd3);

    $display("[TB] ack timeout");
    applyStimulus(5'd1, 1'b0);
    wait_rd_en("t3_rd_en", 4);
    exp_cyc = cyc + ACK_TIMEOUT + 1;
    wait_idle("t3_idle", ACK_TIMEOUT + 10);
    checkOutput("t3_timeout_cycle", cyc, exp_cyc);
    checkOutput("t3_timeout_err", {31'd0, timeout_err}, 32'd1);
    tick(4);
    checkOutput("t3_timeout_sticky", {31'd0, timeout_err}, 32'd1);
    applyStimulus(5'd1, 1'b0);
    wait_rd_en("t3_rd_en2", 4);
    checkOutput("t3_timeout_clear", {31'd0, timeout_err}, 32'd0);
    serve_line(pack8(0, 0, 0, 0, 0, 0, 2, 0), 8'h40, 1'b1, drop_cyc, mx);
    wait_idle("t3_idle2", GAP_CYCLES + 20);
    tick(2);
    checkOutput("t3_queue", exp_q.size(), 32'd0);

    $display("[TB] stop during FIRE of A-line 1 of 4");
    rd_base = rd_count;
    applyStimulus(5'd4, 1'b0);
    wait_rd_en("t4_rd_en0", 4);
    serve_line(pack8(2, 4, 0, 0, 0, 0, 0, 0), 8'h03, 1'b0, drop_cyc, mx);
    wait_rd_en("t4_rd_en1", GAP_CYCLES + 20);
    checkOutput("t4_which", {28'd0, cfg_if.which_aline}, 32'd1);
    serve_line(pack8(5, 2, 0, 0, 0, 0, 0, 0), 8'h03, 1'b0, drop_cyc, mx);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_idle("t4_idle", GAP_CYCLES + 20);
    checkOutput("t4_idle_cycle", cyc, drop_cyc + 2 + mx + GAP_CYCLES);
    tick(GAP_CYCLES + 10);
    checkOutput("t4_queue", exp_q.size(), 32'd0);
    checkOutput("t4_rd_pulses", rd_count - rd_base, 32'd2);

    $display("[TB] all channels at delay 0, then no channels");
    applyStimulus(5'd2, 1'b0);
    wait_rd_en("t5_rd_en0", 4);
    serve_line(pack8(0, 0, 0, 0, 0, 0, 0, 0), 8'hFF, 1'b0, drop_cyc, mx);
    wait_rd_en("t5_rd_en1", GAP_CYCLES + 20);
    serve_line(pack8(1, 2, 3, 4, 5, 6, 7, 8), 8'h00, 1'b1, drop_cyc, mx);
    wait_idle("t5_idle", GAP_CYCLES + 20);
    tick(2);
    checkOutput("t5_queue", exp_q.size(), 32'd0);

    $display("[TB] start blocked by config intake and zero line count");
    rd_base = rd_count;
    intaking_configs = 1'b1;
    applyStimulus(5'd1, 1'b0);
    tick(3);
    checkOutput("t6_intake_busy", {31'd0, busy}, 32'd0);
    intaking_configs = 1'b0;
    applyStimulus(5'd0, 1'b0);
    tick(3);
    checkOutput("t6_zero_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_rd_pulses", rd_count - rd_base, 32'd0);

    $display("[TB] loop_en restart, then stop during REQ");
    rd_base = rd_count;
    applyStimulus(5'd2, 1'b1);
    wait_rd_en("t7_rd_en0", 4);
    serve_line(pack8(1, 0, 0, 0, 0, 0, 0, 0), 8'h01, 1'b0, drop_cyc, mx);
    wait_rd_en("t7_rd_en1", GAP_CYCLES + 20);
    serve_line(pack8(0, 3, 0, 0, 0, 0, 0, 0), 8'h02, 1'b1, drop_cyc, mx);
    wait_rd_en("t7_rd_en2", GAP_CYCLES + 20);
    checkOutput("t7_loop_which", {28'd0, cfg_if.which_aline}, 32'd0);
    stop = 1'b1;
    serve_line(pack8(2, 0, 0, 0, 0, 0, 0, 0), 8'h01, 1'b0, drop_cyc, mx);
    stop    = 1'b0;
    loop_en = 1'b0;
    wait_idle("t7_idle", GAP_CYCLES + 20);
    tick(GAP_CYCLES + 10);
    checkOutput("t7_queue", exp_q.size(), 32'd0);
    checkOutput("t7_rd_pulses", rd_count - rd_base, 32'd3);

    $display("[TB] aline_select=20 clamps to 16 lines");
    rd_base = rd_count;
    applyStimulus(5'd20, 1'b0);
    for (int l = 0; l < 16; l++) begin
      wait_rd_en("t8_rd_en", GAP_CYCLES + 20);
      checkOutput("t8_which", {28'd0, cfg_if.which_aline}, 32'(l));
      serve_line(pack8(l % 3, 1, 2, 3, 0, 1, 2, 3), 8'h01 << (l % 8), (l == 15), drop_cyc, mx);
    end
    wait_idle("t8_idle", GAP_CYCLES + 20);
    tick(GAP_CYCLES + 10);
    checkOutput("t8_queue", exp_q.size(), 32'd0);
    checkOutput("t8_rd_pulses", rd_count - rd_base, 32'd16);

    $display("[TB] reset during WAIT_DONE");
    applyStimulus(5'd2, 1'b0);
    wait_rd_en("t9_rd_en0", 4);
    serve_line(pack8(1, 0, 0, 0, 0, 0, 0, 0), 8'h01, 1'b0, drop_cyc, mx);
    wait_rd_en("t9_rd_en1", GAP_CYCLES + 20);
    checkOutput("t9_which_pre", {28'd0, cfg_if.which_aline}, 32'd1);
    cfg_if.updating_delays = 1'b1;
    tick(3);
    rst = 1'b0;
    #1;
    checkOutput("t9_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("t9_rst_which", {28'd0, cfg_if.which_aline}, 32'd0);
    checkOutput("t9_rst_outs", {22'd0, fire, cfg_if.rd_en, aline_done}, 32'd0);
    tick(2);
    rst = 1'b1;
    cfg_if.updating_delays = 1'b0;
    tick(2);
    applyStimulus(5'd1, 1'b0);
    wait_rd_en("t9_rd_en2", 4);
    checkOutput("t9_which_post", {28'd0, cfg_if.which_aline}, 32'd0);
    serve_line(pack8(0, 0, 4, 4, 0, 0, 0, 0), 8'h0C, 1'b1, drop_cyc, mx);
    wait_idle("t9_idle", GAP_CYCLES + 20);
    tick(2);
    checkOutput("t9_queue", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
